lane_skew_injector: RTL
=======================

LANE_SKEW_INJECTOR -- requirements
Module: lane_skew_injector

Interface
REQ-001 SHALL have parameter DW, default 32: lane data width, 8..64.
REQ-002 SHALL have parameter DEPTH, default 16: skew buffer words, power of 2, at least 4; AW = log2(DEPTH), BW = log2(DW).
REQ-003 SHALL have parameters INIT_MODE (default 2'd0), INIT_WORD_SKEW (default 0) and INIT_BIT_SKEW (default 0): the configuration in force after reset.
REQ-004 SHALL have parameter ERR_PERIOD, default 4096: cycles between injected bit errors.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 SHALL have `clk` (input, 1): sole clock, all state on its rising edge.
REQ-007 SHALL have `rst` (input, 1): async active-high reset.
REQ-008 SHALL have `din` (input, DW): lane word, one per cycle, always valid.
REQ-009 SHALL have `cfg_mode` (input, 2): 00 bypass, 01 word skew, 10 word plus bit skew, 11 treated as 00.
REQ-010 SHALL have `cfg_word_skew` (input, AW): requested word delay.
REQ-011 SHALL have `cfg_bit_skew` (input, BW): requested bit rotation.
REQ-012 SHALL have `cfg_load` (input, 1): one-cycle pulse that latches `cfg_*`.
REQ-013 SHALL have `err_inj_en` (input, 1): enables error injection.
REQ-014 SHALL have `dout` (output, DW): skewed lane word.
REQ-015 SHALL have `dout_vld` (output, 1): `dout` carries stream data.
REQ-016 SHALL have `cur_word_skew` (output, AW) and `cur_bit_skew` (output, BW): the configuration in force.
REQ-017 SHALL have `err_cnt` (output, 16): count of injected errors, saturating.

Function
REQ-018 SHALL implement FSM IDLE->FILL->RUN; IDLE lasts exactly one cycle after reset release, then enters FILL.
REQ-019 SHALL compute latency L = 1 (bypass), W+2 (word), W+3 (bit), where W is the word skew in force.
REQ-020 SHALL, in FILL, hold dout=0 and dout_vld=0 for L cycles, then enter RUN with dout_vld=1.
REQ-021 SHALL make the first valid dout derive from the din sampled in the first FILL cycle.
REQ-022 SHALL write din each cycle at wr_ptr and read at rd_ptr; on FILL entry wr_ptr=W+1 and rd_ptr=0; both increment by 1 and wrap modulo DEPTH.
REQ-023 SHALL clamp cfg_word_skew to DEPTH-2 on load.
REQ-024 SHALL, in bit mode, output {cur[B-1:0], prev[DW-1:B]}, where cur is the current read word and prev the previous one; B=0 passes prev unchanged.
REQ-025 SHALL, in bypass mode, give dout = din delayed one register.
REQ-026 SHALL, on cfg_load in any state, latch config, reset pointers, clear dout_vld on the next cycle and restart FILL.
REQ-027 SHALL, on cfg_load during FILL, restart FILL with the new config.
REQ-028 SHALL ignore cfg_load during IDLE.
REQ-029 SHALL give reset priority over a simultaneous cfg_load.

Reset
REQ-030 SHALL, while rst is high, immediately force dout=0, dout_vld=0, err_cnt=0, pointers=0, state=IDLE, and config=INIT_* (word skew clamped).
REQ-031 SHALL NOT reset buffer contents; stale words are never presented because dout_vld gates them.
REQ-032 SHALL, on reset asserted mid-RUN, force outputs to zero in the same time step without waiting for a clock edge.

Configuration
REQ-033 SHALL, with LANE_SKEW_ERR_EN defined and err_inj_en=1 in RUN, flip exactly one dout bit every ERR_PERIOD cycles.
REQ-034 SHALL select the flipped bit as LFSR mod DW, using a 16-bit LFSR x^16+x^14+x^13+x^11+1 seeded 16'hACE1 at reset.
REQ-035 SHALL increment err_cnt once per injected flip.
REQ-036 SHALL, without LANE_SKEW_ERR_EN, keep the err_inj_en port but ignore it, tie err_cnt to 0 and synthesise no LFSR.

Structure
REQ-037 SHALL place the mode encodings (MODE_BYPASS, MODE_WORD, MODE_BIT), FSM state typedef, LFSR seed and polynomial in shared package pcs_tb_pkg.
REQ-038 SHALL implement the storage as one sub-module, skew_ram (DEPTH x DW, one write and one registered read port per cycle).
REQ-039 SHALL keep the FSM, bit shifter and error logic in the top module.

Verification
REQ-040 SHALL check: DW=32, DEPTH=16, mode 01, W=3, din=1,2,3... -> dout_vld rises 5 cycles after FILL entry, then dout=1,2,3... contiguously.
REQ-041 SHALL check: mode 10, W=0, B=8, din=32'h11111111 then 32'h22222222 -> dout=32'h22111111.
REQ-042 SHALL check: cfg_word_skew=15 with DEPTH=16 -> cur_word_skew=14 and L=16 cycles.
REQ-043 SHALL check: cfg_load mid-RUN changing W 3->6 -> dout_vld low next cycle for 8 cycles, then a contiguous stream resumes.
REQ-044 SHALL check: rst pulsed mid-RUN -> dout=0 and dout_vld=0 immediately, and the INIT_* config is restored.
REQ-045 SHALL check: LANE_SKEW_ERR_EN defined, ERR_PERIOD=100, 1000 RUN cycles -> exactly 10 words differ from expected by a single bit, and err_cnt=10.

Source files
------------

// File: rtl/pcs_tb_pkg.sv
// +-----------------------------------------------------------------------+
// | pcs_tb_pkg : shared encodings for the lane skew injector               |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package pcs_tb_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_WORD   = 2'b01;
    localparam logic [1:0] MODE_BIT    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/skew_ram.sv
// +-----------------------------------------------------------------------+
// | skew_ram : DEPTH x DW buffer, one write and one registered read/cycle  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module skew_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are deliberately not reset; readers gate stale words with valid.
    always_ff @(posedge clk) begin
        mem[wr_addr] <= wr_data;
        rd_data      <= mem[rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/lane_skew_injector.sv
// +-----------------------------------------------------------------------+
// | lane_skew_injector : word/bit skew insertion with optional bit errors  |
// | Optional error injection built only when LANE_SKEW_ERR_EN is defined.  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module lane_skew_injector
    import pcs_tb_pkg::*;
#(
    parameter int         DW             = 32,
    parameter int         DEPTH          = 16,
    parameter logic [1:0] INIT_MODE      = 2'd0,
    parameter int         INIT_WORD_SKEW = 0,
    parameter int         INIT_BIT_SKEW  = 0,
    parameter int         ERR_PERIOD     = 4096,
    localparam int        AW             = $clog2(DEPTH),
    localparam int        BW             = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [1:0]    cfg_mode,
    input  logic [AW-1:0] cfg_word_skew,
    input  logic [BW-1:0] cfg_bit_skew,
    input  logic          cfg_load,
    input  logic          err_inj_en,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic [AW-1:0] cur_word_skew,
    output logic [BW-1:0] cur_bit_skew,
    output logic [15:0]   err_cnt
);

    localparam int INIT_WS = (INIT_WORD_SKEW > DEPTH - 2) ? DEPTH - 2 : INIT_WORD_SKEW;

    state_t        state, state_nxt;
    logic [1:0]    mode_q;
    logic [AW-1:0] wskew_q;
    logic [BW-1:0] bskew_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fill_cnt;
    logic [AW:0]   last_fill;
    logic [DW-1:0] rdata, hold, shifted, data_sel, err_mask;
    logic          start_fill, load_ok;
    logic [AW-1:0] cfg_ws_clamped, ws_next;

    assign load_ok        = cfg_load && (state != ST_IDLE);
    assign cfg_ws_clamped = (cfg_word_skew == AW'(DEPTH - 1)) ? AW'(DEPTH - 2) : cfg_word_skew;
    assign ws_next        = load_ok ? cfg_ws_clamped : wskew_q;

    // FILL lasts latency L cycles; last_fill is L-1.
    always_comb begin
        last_fill = '0;
        case (mode_q)
            MODE_WORD: last_fill = {1'b0, wskew_q} + (AW+1)'(1);
            MODE_BIT:  last_fill = {1'b0, wskew_q} + (AW+1)'(2);
            default:   last_fill = '0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        start_fill = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt  = ST_FILL;
                start_fill = 1'b1;
            end
            ST_FILL: begin
                if (cfg_load) begin
                    start_fill = 1'b1;
                end else if (fill_cnt == last_fill) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_load) begin
                    state_nxt  = ST_FILL;
                    start_fill = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode_q   <= INIT_MODE;
            wskew_q  <= AW'(INIT_WS);
            bskew_q  <= BW'(INIT_BIT_SKEW);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
            hold     <= '0;
        end else begin
            state <= state_nxt;
            if (load_ok) begin
                mode_q  <= cfg_mode;
                wskew_q <= cfg_ws_clamped;
                bskew_q <= cfg_bit_skew;
            end
            // Write leads read by W+1 so a word emerges W+2 cycles after entry.
            if (start_fill) begin
                wr_ptr   <= ws_next + AW'(1);
                rd_ptr   <= '0;
                fill_cnt <= '0;
            end else begin
                wr_ptr   <= wr_ptr + AW'(1);
                rd_ptr   <= rd_ptr + AW'(1);
                if (state == ST_FILL) begin
                    fill_cnt <= fill_cnt + (AW+1)'(1);
                end
            end
            hold <= (mode_q == MODE_WORD || mode_q == MODE_BIT) ? rdata : din;
        end
    end

    skew_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_addr (rd_ptr),
        .rd_data (rdata)
    );

    // {cur, prev} >> B yields {cur[B-1:0], prev[DW-1:B]}.
    assign shifted = DW'({rdata, hold} >> bskew_q);

    always_comb begin
        data_sel = hold;
        case (mode_q)
            MODE_WORD: data_sel = rdata;
            MODE_BIT:  data_sel = shifted;
            default:   data_sel = hold;
        endcase
    end

`ifdef LANE_SKEW_ERR_EN
    localparam int PW = ($clog2(ERR_PERIOD) < 1) ? 1 : $clog2(ERR_PERIOD);

    logic [PW-1:0] per_cnt;
    logic [15:0]   lfsr;
    logic [15:0]   err_cnt_q;
    logic          inj;

    assign inj = (state == ST_RUN) && err_inj_en && (per_cnt == PW'(ERR_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt   <= '0;
            lfsr      <= LFSR_SEED;
            err_cnt_q <= '0;
        end else begin
            if ((state == ST_RUN) && err_inj_en) begin
                per_cnt <= inj ? '0 : per_cnt + PW'(1);
            end
            if (inj) begin
                lfsr <= lfsr_next(lfsr);
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
            end
        end
    end

    assign err_mask = inj ? (DW'(1) << (lfsr % 16'(DW))) : '0;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_err_inj;
    assign unused_err_inj = err_inj_en ^ (ERR_PERIOD == 0);
    assign err_mask       = '0;
    assign err_cnt        = 16'd0;
`endif

    assign dout          = (state == ST_RUN) ? (data_sel ^ err_mask) : '0;
    assign dout_vld      = (state == ST_RUN);
    assign cur_word_skew = wskew_q;
    assign cur_bit_skew  = bskew_q;

endmodule

`default_nettype wire
